// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - bridges core load/store requests onto a handshaked word-wide data bus
module load_store_unit #(
  parameter int TIMEOUT = 16,
  parameter int ADDR_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              stall,
  output logic [31:0]       rdata,
  output logic              misaligned,
  output logic              bus_err,
  output logic              bus_valid,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [31:0]       bus_wdata,
  output logic [3:0]        bus_wstrb,
  input  logic              bus_ready,
  input  logic [31:0]       bus_rdata
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUS  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [1:0]        r_lane;
  logic [2:0]        r_funct3;
  logic              r_we;
  logic [31:0]       r_rdata;
  logic              r_misaligned;
  logic              r_bus_err;
  logic              r_bus_valid;
  logic              r_bus_we;
  logic [ADDR_W-1:0] r_bus_addr;
  logic [31:0]       r_bus_wdata;
  logic [3:0]        r_bus_wstrb;

  logic              w_legal_f3;
  logic              w_aligned;
  logic              w_req_ok;
  logic [3:0]        w_wstrb;
  logic [31:0]       w_wdata;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [31:0]       w_load;

  always_comb begin
    w_legal_f3 = 1'b0;
    if (req_we) begin
      case (req_funct3)
        3'b000, 3'b001, 3'b010: w_legal_f3 = 1'b1;
        default:                w_legal_f3 = 1'b0;
      endcase
    end else begin
      case (req_funct3)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: w_legal_f3 = 1'b1;
        default:                                w_legal_f3 = 1'b0;
      endcase
    end
  end

  always_comb begin
    w_aligned = 1'b0;
    case (req_funct3[1:0])
      2'b00:   w_aligned = 1'b1;
      2'b01:   w_aligned = ~req_addr[0];
      2'b10:   w_aligned = (req_addr[1:0] == 2'b00);
      default: w_aligned = 1'b0;
    endcase
  end

  assign w_req_ok = w_legal_f3 && w_aligned;

  // Store data is replicated across lanes so the slave only has to honour the strobes.
  always_comb begin
    w_wstrb = 4'b0000;
    w_wdata = 32'd0;
    if (req_we) begin
      case (req_funct3[1:0])
        2'b00: begin
          w_wstrb = 4'b0001 << req_addr[1:0];
          w_wdata = {4{req_wdata[7:0]}};
        end
        2'b01: begin
          w_wstrb = 4'b0011 << req_addr[1:0];
          w_wdata = {2{req_wdata[15:0]}};
        end
        default: begin
          w_wstrb = 4'b1111;
          w_wdata = req_wdata;
        end
      endcase
    end
  end

  assign w_byte = bus_rdata[{r_lane, 3'b000} +: 8];
  assign w_half = r_lane[1] ? bus_rdata[31:16] : bus_rdata[15:0];

  always_comb begin
    w_load = 32'd0;
    case (r_funct3)
      3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_load = {{16{w_half[15]}}, w_half};
      3'b010:  w_load = bus_rdata;
      3'b100:  w_load = {24'd0, w_byte};
      3'b101:  w_load = {16'd0, w_half};
      default: w_load = 32'd0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_lane       <= 2'b00;
      r_funct3     <= 3'b000;
      r_we         <= 1'b0;
      r_rdata      <= 32'd0;
      r_misaligned <= 1'b0;
      r_bus_err    <= 1'b0;
      r_bus_valid  <= 1'b0;
      r_bus_we     <= 1'b0;
      r_bus_addr   <= '0;
      r_bus_wdata  <= 32'd0;
      r_bus_wstrb  <= 4'b0000;
    end else begin
      r_misaligned <= 1'b0;
      r_bus_err    <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (req_valid) begin
            if (w_req_ok) begin
              r_bus_valid <= 1'b1;
              r_bus_we    <= req_we;
              r_bus_addr  <= {req_addr[ADDR_W-1:2], 2'b00};
              r_bus_wdata <= w_wdata;
              r_bus_wstrb <= w_wstrb;
              r_lane      <= req_addr[1:0];
              r_funct3    <= req_funct3;
              r_we        <= req_we;
              r_state     <= S_BUS;
            end else begin
              r_misaligned <= 1'b1;
              r_rdata      <= 32'd0;
              r_state      <= S_DONE;
            end
          end
        end
        S_BUS: begin
          // A transfer completing on the last allowed cycle takes priority over the timeout.
          if (bus_ready) begin
            r_rdata     <= r_we ? 32'd0 : w_load;
            r_bus_valid <= 1'b0;
            r_bus_we    <= 1'b0;
            r_bus_wstrb <= 4'b0000;
            r_state     <= S_DONE;
          end else if (r_cnt == CNT_LAST) begin
            r_rdata     <= 32'd0;
            r_bus_err   <= 1'b1;
            r_bus_valid <= 1'b0;
            r_bus_we    <= 1'b0;
            r_bus_wstrb <= 4'b0000;
            r_state     <= S_DONE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign stall      = rst && ((r_state == S_BUS) || ((r_state == S_IDLE) && req_valid));
  assign rdata      = r_rdata;
  assign misaligned = r_misaligned;
  assign bus_err    = r_bus_err;
  assign bus_valid  = r_bus_valid;
  assign bus_we     = r_bus_we;
  assign bus_addr   = r_bus_addr;
  assign bus_wdata  = r_bus_wdata;
  assign bus_wstrb  = r_bus_wstrb;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - table, hand-written and random checks of load_store_unit against a reference model
module tb_load_store_unit;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        stall;
  logic [31:0] rdata;
  logic        misaligned;
  logic        bus_err;
  logic        bus_valid;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_wstrb;
  logic        bus_ready;
  logic [31:0] bus_rdata;

  int n_checks = 0;
  int n_errors = 0;

  load_store_unit #(.TIMEOUT(TO), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_we(req_we), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .stall(stall), .rdata(rdata), .misaligned(misaligned), .bus_err(bus_err),
    .bus_valid(bus_valid), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb),
    .bus_ready(bus_ready), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  typedef struct {
    int unsigned stall_cnt;
    int unsigned valid_cnt;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [3:0]  wstrb;
    logic        we;
    logic        mis;
    logic        err;
  } res_t;

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          delay;
    logic [31:0] word;
    res_t        exp;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Expected outcome derived from the access rules with plain arithmetic.
  function automatic res_t model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                 input logic [31:0] wdata, input int delay, input logic [31:0] word);
    res_t e;
    int size;
    int off;
    bit legal;
    logic [63:0] v;
    e = '{default: 0};
    legal = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    size = 1 << f3[1:0];
    off = int'(addr % 4);
    if (!legal || (addr % size) != 0) begin
      e.stall_cnt = 1;
      e.mis = 1'b1;
      return e;
    end
    e.addr = addr & 32'hFFFF_FFFC;
    e.we = we;
    if (we) begin
      e.wstrb = 4'(((1 << size) - 1) << off);
      if (size == 1)      e.wdata = 32'(wdata[7:0]) * 32'h0101_0101;
      else if (size == 2) e.wdata = 32'(wdata[15:0]) * 32'h0001_0001;
      else                e.wdata = wdata;
    end
    if (delay < TO) begin
      e.valid_cnt = delay + 1;
      e.stall_cnt = delay + 2;
      if (!we) begin
        v = (64'(word) >> (8 * off)) & ((64'd1 << (8 * size)) - 64'd1);
        if (!f3[2] && size < 4 && v >= (64'd1 << (8 * size - 1)))
          v = v - (64'd1 << (8 * size));
        e.rdata = v[31:0];
      end
    end else begin
      e.valid_cnt = TO;
      e.stall_cnt = TO + 1;
      e.err = 1'b1;
    end
    return e;
  endfunction

  // Drives one request starting just after a rising edge, plays the slave, returns just after DONE's edge.
  task automatic run_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input int delay, input logic [31:0] word,
                         output res_t r, output int stray, output int unstable, output bit tmo);
    int cyc;
    bit done;
    r = '{default: 0};
    stray = 0;
    unstable = 0;
    tmo = 1'b0;
    done = 1'b0;
    cyc = 0;
    req_valid = 1'b1;
    req_we = we;
    req_funct3 = f3;
    req_addr = addr;
    req_wdata = wdata;
    while (!done) begin
      @(negedge clk);
      if (stall) r.stall_cnt++;
      if (bus_valid) begin
        if (r.valid_cnt == 0) begin
          r.addr = bus_addr;
          r.wstrb = bus_wstrb;
          r.wdata = bus_wdata;
          r.we = bus_we;
        end else if (bus_addr !== r.addr || bus_wstrb !== r.wstrb || bus_wdata !== r.wdata || bus_we !== r.we) begin
          unstable++;
        end
        bus_ready = (r.valid_cnt == delay);
        bus_rdata = bus_ready ? word : $urandom;
        r.valid_cnt++;
      end else begin
        bus_ready = 1'b0;
        bus_rdata = $urandom;
      end
      if (!stall) begin
        done = 1'b1;
        r.rdata = rdata;
        r.mis = misaligned;
        r.err = bus_err;
      end else if (misaligned || bus_err) begin
        stray++;
      end
      cyc++;
      if (!done && cyc >= 40) begin
        tmo = 1'b1;
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    req_valid = 1'b0;
    bus_ready = 1'b0;
  endtask

  task automatic compare(input string tag, input res_t e, input res_t o, input logic we,
                         input int stray, input int unstable, input bit tmo);
    chk({tag, ".timeout"}, 32'(tmo), 32'd0);
    chk({tag, ".stall_cycles"}, o.stall_cnt, e.stall_cnt);
    chk({tag, ".valid_cycles"}, o.valid_cnt, e.valid_cnt);
    if (e.valid_cnt != 0) begin
      chk({tag, ".bus_addr"}, o.addr, e.addr);
      chk({tag, ".bus_wstrb"}, 32'(o.wstrb), 32'(e.wstrb));
      chk({tag, ".bus_we"}, 32'(o.we), 32'(e.we));
      chk({tag, ".bus_stable"}, unstable, 32'd0);
      if (we) chk({tag, ".bus_wdata"}, o.wdata, e.wdata);
    end
    chk({tag, ".misaligned"}, 32'(o.mis), 32'(e.mis));
    chk({tag, ".bus_err"}, 32'(o.err), 32'(e.err));
    if (!e.mis) chk({tag, ".rdata"}, o.rdata, e.rdata);
    chk({tag, ".stray_pulse"}, stray, 32'd0);
  endtask

  task automatic add(input logic we, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wdata,
                     input int delay, input logic [31:0] word, input int stl, input int vld,
                     input logic [31:0] eaddr, input logic [3:0] estrb, input logic [31:0] ewdata,
                     input logic [31:0] erdata, input logic emis, input logic eerr);
    vec_t v;
    v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.delay = delay; v.word = word;
    v.exp.stall_cnt = stl; v.exp.valid_cnt = vld; v.exp.addr = eaddr; v.exp.wstrb = estrb;
    v.exp.wdata = ewdata; v.exp.rdata = erdata; v.exp.we = we; v.exp.mis = emis; v.exp.err = eerr;
    vq.push_back(v);
  endtask

  initial begin
    res_t o;
    res_t e;
    int stray;
    int unstable;
    bit tmo;

    rst = 1'b0;
    req_valid = 1'b1;
    req_we = 1'b1;
    req_funct3 = 3'b010;
    req_addr = 32'h0000_0100;
    req_wdata = 32'hFFFF_FFFF;
    bus_ready = 1'b0;
    bus_rdata = 32'd0;
    repeat (2) @(negedge clk);
    chk("reset.stall", 32'(stall), 32'd0);
    chk("reset.rdata", rdata, 32'd0);
    chk("reset.misaligned", 32'(misaligned), 32'd0);
    chk("reset.bus_err", 32'(bus_err), 32'd0);
    chk("reset.bus_valid", 32'(bus_valid), 32'd0);
    chk("reset.bus_we", 32'(bus_we), 32'd0);
    chk("reset.bus_addr", bus_addr, 32'd0);
    chk("reset.bus_wdata", bus_wdata, 32'd0);
    chk("reset.bus_wstrb", 32'(bus_wstrb), 32'd0);
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;

    //   we    f3      addr          wdata         dly word          stl vld eaddr         strb     ewdata        erdata        mis   err
    add(1'b0, 3'b010, 32'h0000_0100, 32'h0,        0, 32'hDEAD_BEEF, 2,  1, 32'h0000_0100, 4'b0000, 32'h0,        32'hDEAD_BEEF, 1'b0, 1'b0);
    add(1'b0, 3'b000, 32'h0000_0103, 32'h0,        0, 32'h80FF_1234, 2,  1, 32'h0000_0100, 4'b0000, 32'h0,        32'hFFFF_FF80, 1'b0, 1'b0);
    add(1'b0, 3'b100, 32'h0000_0103, 32'h0,        0, 32'h80FF_1234, 2,  1, 32'h0000_0100, 4'b0000, 32'h0,        32'h0000_0080, 1'b0, 1'b0);
    add(1'b1, 3'b000, 32'h0000_0022, 32'h0000_00A5, 0, 32'h0,        2,  1, 32'h0000_0020, 4'b0100, 32'hA5A5_A5A5, 32'h0,        1'b0, 1'b0);
    add(1'b1, 3'b001, 32'h0000_0022, 32'h0000_1234, 1, 32'h0,        3,  2, 32'h0000_0020, 4'b1100, 32'h1234_1234, 32'h0,        1'b0, 1'b0);
    add(1'b0, 3'b010, 32'h0000_0102, 32'h0,        0, 32'h0,         1,  0, 32'h0,         4'b0000, 32'h0,        32'h0,        1'b1, 1'b0);
    add(1'b0, 3'b011, 32'h0000_0100, 32'h0,        0, 32'h0,         1,  0, 32'h0,         4'b0000, 32'h0,        32'h0,        1'b1, 1'b0);
    add(1'b0, 3'b010, 32'h0000_0104, 32'h0,       99, 32'h1111_1111, 5,  4, 32'h0000_0104, 4'b0000, 32'h0,        32'h0,        1'b0, 1'b1);
    add(1'b0, 3'b010, 32'h0000_0108, 32'h0,        3, 32'h1357_9BDF, 5,  4, 32'h0000_0108, 4'b0000, 32'h0,        32'h1357_9BDF, 1'b0, 1'b0);
    add(1'b0, 3'b001, 32'h0000_0202, 32'h0,        0, 32'h8001_7FFF, 2,  1, 32'h0000_0200, 4'b0000, 32'h0,        32'hFFFF_8001, 1'b0, 1'b0);
    add(1'b0, 3'b101, 32'h0000_0202, 32'h0,        2, 32'h8001_7FFF, 4,  3, 32'h0000_0200, 4'b0000, 32'h0,        32'h0000_8001, 1'b0, 1'b0);
    add(1'b1, 3'b010, 32'h0000_0040, 32'hCAFE_F00D, 0, 32'h0,        2,  1, 32'h0000_0040, 4'b1111, 32'hCAFE_F00D, 32'h0,        1'b0, 1'b0);
    add(1'b1, 3'b001, 32'h0000_0041, 32'h0000_5555, 0, 32'h0,        1,  0, 32'h0,         4'b0000, 32'h0,        32'h0,        1'b1, 1'b0);
    add(1'b1, 3'b100, 32'h0000_0040, 32'h0000_5555, 0, 32'h0,        1,  0, 32'h0,         4'b0000, 32'h0,        32'h0,        1'b1, 1'b0);
    add(1'b0, 3'b110, 32'h0000_0040, 32'h0,        0, 32'h0,         1,  0, 32'h0,         4'b0000, 32'h0,        32'h0,        1'b1, 1'b0);

    for (int i = 0; i < vq.size(); i++) begin
      run_req(vq[i].we, vq[i].f3, vq[i].addr, vq[i].wdata, vq[i].delay, vq[i].word, o, stray, unstable, tmo);
      compare($sformatf("vec%0d", i), vq[i].exp, o, vq[i].we, stray, unstable, tmo);
    end

    // Reset asserted while the bus transaction is outstanding.
    req_valid = 1'b1;
    req_we = 1'b0;
    req_funct3 = 3'b010;
    req_addr = 32'h0000_0500;
    req_wdata = 32'd0;
    bus_ready = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_bus.pre_valid", 32'(bus_valid), 32'd1);
    chk("rst_bus.pre_stall", 32'(stall), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("rst_bus.async_valid", 32'(bus_valid), 32'd0);
    chk("rst_bus.async_stall", 32'(stall), 32'd0);
    chk("rst_bus.async_addr", bus_addr, 32'd0);
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("rst_bus.no_retry_valid", 32'(bus_valid), 32'd0);
      chk("rst_bus.idle_stall", 32'(stall), 32'd0);
      @(posedge clk);
      #1;
    end
    run_req(1'b0, 3'b010, 32'h0000_0300, 32'h0, 0, 32'h1122_3344, o, stray, unstable, tmo);
    e = model(1'b0, 3'b010, 32'h0000_0300, 32'h0, 0, 32'h1122_3344);
    compare("b2b_lw", e, o, 1'b0, stray, unstable, tmo);
    run_req(1'b1, 3'b010, 32'h0000_0304, 32'h5566_7788, 1, 32'h0, o, stray, unstable, tmo);
    e = model(1'b1, 3'b010, 32'h0000_0304, 32'h5566_7788, 1, 32'h0);
    compare("b2b_sw", e, o, 1'b1, stray, unstable, tmo);

    for (int i = 0; i < 150; i++) begin
      logic        we;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] word;
      int          delay;
      we = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 4) == 0) f3 = 3'($urandom_range(0, 7));
      else if (we) f3 = 3'($urandom_range(0, 2));
      else begin
        f3 = 3'($urandom_range(0, 4));
        if (f3 == 3'd3) f3 = 3'd5;
      end
      addr = $urandom;
      wdata = $urandom;
      word = $urandom;
      delay = $urandom_range(0, 5);
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) begin
          @(posedge clk);
          #1;
        end
      end
      run_req(we, f3, addr, wdata, delay, word, o, stray, unstable, tmo);
      e = model(we, f3, addr, wdata, delay, word);
      compare($sformatf("rand%0d", i), e, o, we, stray, unstable, tmo);
    end

    @(negedge clk);
    chk("final.misaligned_low", 32'(misaligned), 32'd0);
    chk("final.bus_err_low", 32'(bus_err), 32'd0);
    chk("final.stall_low", 32'(stall), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits directly downstream of the single-cycle core datapath.
- Replaces the zero-latency data memory with a handshaked word-wide data bus.
- Converts core load/store requests (address, write data, funct3) into aligned bus transactions with byte strobes and sign/zero-extends load data.
- Asserts a stall so the core freezes its PC and register-file write until the access completes.

Parameters:
- TIMEOUT, 16, bus cycles to wait for bus_ready before aborting with bus_err (minimum 1).
- ADDR_W, 32, width of req_addr and bus_addr.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- req_valid  in  1  core issues a load or store this cycle
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RISC-V funct3 of the load/store
- req_addr  in  ADDR_W  byte address (ALU result)
- req_wdata  in  32  store data (rs2 value)
- stall  out  1  core must hold PC and all request inputs stable
- rdata  out  32  extended load result, valid in the DONE cycle
- misaligned  out  1  one-cycle pulse: misaligned access or illegal funct3
- bus_err  out  1  one-cycle pulse: bus timeout
- bus_valid  out  1  transaction request, registered
- bus_we  out  1  registered
- bus_addr  out  ADDR_W  word-aligned address, bits [1:0] = 00, registered
- bus_wdata  out  32  lane-shifted store data, registered
- bus_wstrb  out  4  byte strobes, all 0 for loads, registered
- bus_ready  in  1  slave completes transfer this cycle
- bus_rdata  in  32  read word, valid when bus_ready=1 and bus_we=0

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; all outputs 0; timeout counter 0. Reset mid-transaction drops bus_valid immediately; the aborted access is not retried.
- FSM states: IDLE, BUS, DONE.
- IDLE:
  - stall = req_valid (combinational).
  - With req_valid=1 and a legal, aligned request: latch bus fields, go to BUS.
  - With req_valid=1 and an illegal/misaligned request: go to DONE with misaligned pulse pending. No bus activity.
- BUS:
  - bus_valid=1; stall=1; counter increments each cycle.
  - bus_ready=1: capture bus_rdata, go to DONE.
  - Counter reaches TIMEOUT-1 without bus_ready: drop bus_valid, go to DONE with bus_err pulse and rdata=0.
  - bus_ready and timeout in the same cycle: bus_ready wins, no error.
- DONE:
  - stall=0; rdata valid; misaligned or bus_err pulses here.
  - Always returns to IDLE next cycle. A new req_valid is handled in that IDLE cycle.
- Minimum latency: request accepted in cycle 0, BUS in cycle 1 with immediate bus_ready, DONE in cycle 2. The core stalls 2 cycles.
- Bus outputs are stable while bus_valid=1. They are cleared (valid/we/wstrb to 0) on leaving BUS.
- Legal funct3:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Anything else is illegal and flagged as misaligned.
- Alignment:
  - Halfword requires addr[0]=0.
  - Word requires addr[1:0]=00.
  - Byte is always aligned.
- Stores:
  - SB: wstrb = 0001 << addr[1:0]; wdata = byte replicated to all four lanes.
  - SH: wstrb = 0011 << addr[1:0]; wdata = halfword replicated to both halves.
  - SW: wstrb = 1111.
- Loads:
  - Select the lane by captured addr[1:0].
  - LB/LH sign-extend; LBU/LHU zero-extend.
  - rdata for a store is 0.
  - rdata holds its last value until the next DONE.
- Changing request inputs while stall=1 is a protocol violation; the unit uses latched values.

Test Plan:
- LW addr=0x100, slave returns 0xDEADBEEF with bus_ready in the first BUS cycle -> bus_addr=0x100, wstrb=0000, stall high 2 cycles, rdata=0xDEADBEEF in DONE.
- LB addr=0x103, bus_rdata=0x80FF1234 -> rdata=0xFFFFFF80. LBU at the same address -> rdata=0x00000080.
- SB addr=0x22, req_wdata=0x000000A5 -> bus_addr=0x20, wstrb=0100, wdata=0xA5A5A5A5. SH addr=0x22, req_wdata=0x00001234 -> wstrb=1100, wdata=0x12341234.
- LW addr=0x102 -> no bus_valid, misaligned pulses in cycle 1, stall high exactly 1 cycle. funct3=011 gives the same response.
- TIMEOUT=4, slave never ready -> bus_valid high 4 cycles, then bus_err pulse, rdata=0, stall released. Ready on the 4th cycle -> no bus_err.
- rst driven low while in BUS -> bus_valid, stall and state clear without waiting for a clock edge. After release, a back-to-back LW/SW pair completes in order with correct data.
